// File: rtl/lcd_pkg.sv
// Shared encodings for the HD44780-style bus responder.
// Optional busy-timing model: define LCD_BUSY_MODEL_EN.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPCTL = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE_END   = 7'h27;
  localparam logic [7:0] SPACE      = 8'h20;

  // True when m is the highest set bit of d.
  function automatic logic cmd_hit(logic [7:0] d, logic [7:0] m);
    logic [7:0] hi;
    hi = ~((m << 1) - 8'd1);
    return ((d & hi) == 8'h00) && ((d & m) != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Next address-counter value with HD44780 two-line wrap rules.
// Out-of-range addresses step with plain 7-bit wrap.
module lcd_ac_step
  import lcd_pkg::*;
(
  input  logic [6:0] ac_i,
  input  logic       inc_i,
  output logic [6:0] ac_o
);

  always_comb begin
    ac_o = inc_i ? ac_i + 7'd1 : ac_i - 7'd1;
    if (inc_i) begin
      if (ac_i == LINE_END)
        ac_o = LINE1_BASE;
      else if (ac_i == LINE1_BASE + LINE_END)
        ac_o = 7'h00;
    end else begin
      if (ac_i == 7'h00)
        ac_o = LINE1_BASE + LINE_END;
      else if (ac_i == LINE1_BASE)
        ac_o = LINE_END;
    end
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// Display-side responder for the 8-bit LCD bus: 2x16 DDRAM, AC, flags.
// Define LCD_BUSY_MODEL_EN to enforce command busy timing.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int CLEAR_CYCLES = 82,
  parameter int HOME_CYCLES  = 82,
  parameter int CMD_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  output logic [7:0] lcd_dout,
  output logic       lcd_dout_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic       busy,
  output logic       char_valid,
  output logic       cmd_valid,
  output logic       overrun
);

  localparam int WAIT_W =
    $clog2(CLEAR_CYCLES + HOME_CYCLES + CMD_CYCLES + 1);
  // WAIT lengths exclude the accept cycle and, for clear, the fill.
`ifdef LCD_BUSY_MODEL_EN
  localparam int CLR_W  = CLEAR_CYCLES - 33;
  localparam int HOME_W = HOME_CYCLES - 1;
  localparam int CMD_W  = CMD_CYCLES - 1;
`else
  localparam int CLR_W  = 0;
  localparam int HOME_W = 0;
  localparam int CMD_W  = 0;
`endif

  logic [7:0]        data_q;
  logic              rs_q, rw_q, en_q;
  lcd_state_e        state_q, state_d;
  logic [4:0]        fill_q, fill_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        ddram_q [32];
  logic [6:0]        ac_q, ac_d, ac_nx;
  logic              disp_q, disp_d, curs_q, curs_d;
  logic              blink_q, blink_d, inc_q, inc_d;
  logic              shift_q, shift_d, ovr_q;
  logic              cmd_q, chr_q, oe_q;
  logic [7:0]        dout_q, rdd_q, ddram_rd;
  logic              strobe, wr_stb, rd_stb, busy_w;
  logic              acc, cmd_acc, chr_acc, inc_sel;
  logic              wr_en, cmd_pulse, chr_pulse;
  logic [4:0]        wr_idx;
  logic [7:0]        wr_val;

  assign busy_w  = (state_q != IDLE);
  assign strobe  = en_q & ~lcd_en;
  assign wr_stb  = strobe & ~rw_q;
  assign rd_stb  = strobe & rw_q;
  assign acc     = wr_stb & ~busy_w;
  assign cmd_acc = acc & ~rs_q & (data_q != 8'h00);
  assign chr_acc = acc & rs_q;
  assign inc_sel = (~rs_q & cmd_hit(data_q, CMD_SHIFT)) ?
                   data_q[2] : inc_q;
  assign ddram_rd = (ac_q[5:4] == 2'b00) ?
                    ddram_q[{ac_q[6], ac_q[3:0]}] : SPACE;

  lcd_ac_step u_step (
    .ac_i  (ac_q),
    .inc_i (inc_sel),
    .ac_o  (ac_nx)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    wait_d    = wait_q;
    ac_d      = ac_q;
    disp_d    = disp_q;
    curs_d    = curs_q;
    blink_d   = blink_q;
    inc_d     = inc_q;
    shift_d   = shift_q;
    wr_en     = 1'b0;
    wr_idx    = fill_q;
    wr_val    = SPACE;
    cmd_pulse = 1'b0;
    chr_pulse = 1'b0;
    unique case (state_q)
      FILL: begin
        wr_en  = 1'b1;
        fill_d = fill_q + 5'd1;
        if (fill_q == 5'd31) begin
          state_d = IDLE;
          if (CLR_W > 0) begin
            state_d = WAIT;
            wait_d  = WAIT_W'(CLR_W - 1);
          end
        end
      end
      WAIT: begin
        if (wait_q == '0) state_d = IDLE;
        else wait_d = wait_q - WAIT_W'(1);
      end
      default: ;
    endcase
    if (rd_stb && rs_q) ac_d = ac_nx;
    if (chr_acc) begin
      chr_pulse = 1'b1;
      ac_d      = ac_nx;
      if (ac_q[5:4] == 2'b00) begin
        wr_en  = 1'b1;
        wr_idx = {ac_q[6], ac_q[3:0]};
        wr_val = data_q;
      end
      if (CMD_W > 0) begin
        state_d = WAIT;
        wait_d  = WAIT_W'(CMD_W - 1);
      end
    end
    if (cmd_acc) begin
      cmd_pulse = 1'b1;
      if (CMD_W > 0) begin
        state_d = WAIT;
        wait_d  = WAIT_W'(CMD_W - 1);
      end
      unique case (1'b1)
        cmd_hit(data_q, CMD_DDRAM): ac_d = data_q[6:0];
        cmd_hit(data_q, CMD_SHIFT): begin
          if (!data_q[3]) ac_d = ac_nx;
        end
        cmd_hit(data_q, CMD_DISPCTL): begin
          {disp_d, curs_d, blink_d} = data_q[2:0];
        end
        cmd_hit(data_q, CMD_ENTRY): {inc_d, shift_d} = data_q[1:0];
        cmd_hit(data_q, CMD_HOME): begin
          ac_d    = '0;
          state_d = IDLE;
          if (HOME_W > 0) begin
            state_d = WAIT;
            wait_d  = WAIT_W'(HOME_W - 1);
          end
        end
        cmd_hit(data_q, CMD_CLEAR): begin
          ac_d    = '0;
          inc_d   = 1'b1;
          state_d = FILL;
          fill_d  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      en_q    <= 1'b0;
      state_q <= IDLE;
      fill_q  <= '0;
      wait_q  <= '0;
      ac_q    <= '0;
      disp_q  <= 1'b0;
      curs_q  <= 1'b0;
      blink_q <= 1'b0;
      inc_q   <= 1'b1;
      shift_q <= 1'b0;
      ovr_q   <= 1'b0;
      cmd_q   <= 1'b0;
      chr_q   <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      rdd_q   <= SPACE;
      for (int i = 0; i < 32; i++) ddram_q[i] <= SPACE;
    end else begin
      data_q  <= lcd_data;
      rs_q    <= lcd_rs;
      rw_q    <= lcd_rw;
      en_q    <= lcd_en;
      state_q <= state_d;
      fill_q  <= fill_d;
      wait_q  <= wait_d;
      ac_q    <= ac_d;
      disp_q  <= disp_d;
      curs_q  <= curs_d;
      blink_q <= blink_d;
      inc_q   <= inc_d;
      shift_q <= shift_d;
      ovr_q   <= ovr_q | (wr_stb & busy_w);
      cmd_q   <= cmd_pulse;
      chr_q   <= chr_pulse;
      oe_q    <= lcd_rw & lcd_en;
      if (lcd_rw && lcd_en)
        dout_q <= lcd_rs ? ddram_rd : {busy_w, ac_q};
      // Forward this cycle's write so rd_data shows the settled entry.
      rdd_q <= (wr_en && wr_idx == rd_addr) ? wr_val : ddram_q[rd_addr];
      if (wr_en) ddram_q[wr_idx] <= wr_val;
    end
  end

  assign lcd_dout    = dout_q;
  assign lcd_dout_oe = oe_q;
  assign rd_data     = rdd_q;
  assign ac          = ac_q;
  assign display_on  = disp_q;
  assign cursor_on   = curs_q;
  assign blink_on    = blink_q;
  assign entry_inc   = inc_q;
  assign entry_shift = shift_q;
  assign busy        = busy_w;
  assign char_valid  = chr_q;
  assign cmd_valid   = cmd_q;
  assign overrun     = ovr_q;

endmodule
